// File: rtl/ask_rx_pkg.sv
// rtl/ask_rx_pkg.sv - shared types and default constants for the ASK receive path
// Purpose: sync_state encoding and default bit-synchroniser parameters.
// Ports: none.
package ask_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  localparam int BITSYNC_DIV         = 32;  // clk32 cycles per symbol
  localparam int BITSYNC_WIN         = 4;   // |phase error| accepted as a good edge
  localparam int BITSYNC_LOCK_CNT    = 8;   // good edges in TRACK before LOCKED
  localparam int BITSYNC_MISS_MAX    = 4;   // bad edges in LOCKED before SEARCH
  localparam int BITSYNC_TIMEOUT_SYM = 16;  // edgeless symbols before loss of lock

endpackage

// File: rtl/ask_bitsync_ctrl_nco.sv
// rtl/ask_bitsync_ctrl_nco.sv - symbol-phase counter with hold/advance and mid-bit strobe
// Purpose: free-running modulo-DIV phase counter, edge phase error, sampling strobe.
// Ports:
//   wrap_o     out  counter wrapped this cycle (BITSYNC_TIMEOUT_EN builds only)
//   clk32      in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   edge_p_i   in   single-cycle transition event
//   coarse_i   in   force cnt to 1 (edge taken as the new phase origin)
//   data_in    in   hard-decision data, captured at the sample point
//   cnt_o      out  current phase count
//   err_o      out  signed phase error of an edge seen at the current count
//   bit_stb_o  out  registered one-cycle strobe, cycle after cnt == DIV/2
//   bit_out_o  out  data_in captured with bit_stb_o
module bitsync_nco
  import ask_rx_pkg::*;
#(
  parameter int DIV = BITSYNC_DIV
) (
`ifdef BITSYNC_TIMEOUT_EN
  output logic                   wrap_o,
`endif
  input  logic                   clk32,
  input  logic                   rst,
  input  logic                   edge_p_i,
  input  logic                   coarse_i,
  input  logic                   data_in,
  output logic [$clog2(DIV)-1:0] cnt_o,
  output logic [$clog2(DIV):0]   err_o,
  output logic                   bit_stb_o,
  output logic                   bit_out_o
);

  localparam int CW  = $clog2(DIV);
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] HALF  = CW'(DIV / 2);
  localparam logic [CW:0]   DIV_W = CW1'(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          bout_q, bout_d;
  logic [1:0]    inc;
  logic [CW:0]   sum;
  logic          wrap;

  // An edge late in the first half-symbol (err > 0) holds the count, one in the
  // second half (err < 0) advances it. A hold can therefore only happen below
  // DIV/2 and an advance only from DIV/2 upward, after the strobe decision has
  // been taken from the current count, so DIV/2 is never skipped or repeated.
  always_comb begin
    inc = 2'd1;
    if (edge_p_i) begin
      if (cnt_q >= HALF) begin
        inc = 2'd2;
      end else if (cnt_q != '0) begin
        inc = 2'd0;
      end
    end
    sum   = {1'b0, cnt_q} + {{(CW - 1){1'b0}}, inc};
    wrap  = (sum >= DIV_W);
    cnt_d = wrap ? CW'(sum - DIV_W) : sum[CW-1:0];
    if (coarse_i) begin
      cnt_d = CW'(1);
    end
    stb_d  = (cnt_q == HALF);
    bout_d = stb_d ? data_in : bout_q;
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      stb_q  <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      stb_q  <= stb_d;
      bout_q <= bout_d;
    end
  end

  // Second-half counts map to negative errors: cnt - DIV in two's complement.
  assign err_o     = {1'b0, cnt_q} - ((cnt_q >= HALF) ? DIV_W : '0);
  assign cnt_o     = cnt_q;
  assign bit_stb_o = stb_q;
  assign bit_out_o = bout_q;
`ifdef BITSYNC_TIMEOUT_EN
  assign wrap_o    = wrap;
`endif

endmodule

// File: rtl/ask_bitsync_ctrl.sv
// rtl/ask_bitsync_ctrl.sv - early/late bit-synchronisation controller for the ASK receiver
// Purpose: detects transition events, runs SEARCH/TRACK/LOCKED acquisition and
//          steers the phase counter so one strobe per symbol lands mid-bit.
// Optional feature: BITSYNC_TIMEOUT_EN adds a symbol timeout (TIMEOUT_SYM edgeless
//          symbols in TRACK or LOCKED return to SEARCH).
// Ports:
//   rst         in   asynchronous active-high reset
//   clk32       in   system clock, rising edge
//   edge_in     in   stretched transition pulse
//   data_in     in   hard-decision data
//   bit_stb     out  one-cycle strobe per symbol (free-running in every state)
//   bit_out     out  data_in captured at the bit_stb cycle
//   locked      out  high in LOCKED
//   sync_state  out  SEARCH=0, TRACK=1, LOCKED=2
//   phase_err   out  signed error of the last edge, held until the next edge
module ask_bitsync_ctrl
  import ask_rx_pkg::*;
#(
  parameter int DIV         = BITSYNC_DIV,
  parameter int WIN         = BITSYNC_WIN,
  parameter int LOCK_CNT    = BITSYNC_LOCK_CNT,
`ifdef BITSYNC_TIMEOUT_EN
  parameter int TIMEOUT_SYM = BITSYNC_TIMEOUT_SYM,
`endif
  parameter int MISS_MAX    = BITSYNC_MISS_MAX
) (
  input  logic                 rst,
  input  logic                 clk32,
  input  logic                 edge_in,
  input  logic                 data_in,
  output logic                 bit_stb,
  output logic                 bit_out,
  output logic                 locked,
  output logic [1:0]           sync_state,
  output logic [$clog2(DIV):0] phase_err
);

  localparam int CW = $clog2(DIV);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [CW-1:0] WIN_LO = CW'(WIN);
  localparam logic [CW-1:0] WIN_HI = CW'(DIV - WIN);
  localparam logic [GW-1:0] LOCK_C = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_C = MW'(MISS_MAX);

  sync_state_e   state_q, state_d;
  logic          edge_q;
  logic          edge_p;
  logic          coarse;
  logic          in_win;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [CW:0]   perr_q, perr_d;
  logic [CW-1:0] cnt;
  logic [CW:0]   err;
  logic          timeout;

  // One event per stretched pulse regardless of its width.
  assign edge_p = edge_in & ~edge_q;

  // |err| <= WIN expressed on the raw count: near 0 from either side.
  assign in_win = (cnt <= WIN_LO) || (cnt >= WIN_HI);

`ifdef BITSYNC_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_SYM + 1);
  localparam logic [SW-1:0] TMO_C = SW'(TIMEOUT_SYM);

  logic          wrap;
  logic [SW-1:0] sym_q, sym_d;

  // Saturates at TIMEOUT_SYM; an edge in the same cycle wins over the timeout.
  always_comb begin
    sym_d = sym_q;
    if (edge_p) begin
      sym_d = '0;
    end else if (wrap && (sym_q != TMO_C)) begin
      sym_d = sym_q + 1'b1;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      sym_q <= '0;
    end else begin
      sym_q <= sym_d;
    end
  end

  assign timeout = (sym_q == TMO_C) && !edge_p;
`else
  assign timeout = 1'b0;
`endif

  bitsync_nco #(
    .DIV (DIV)
  ) u_nco (
`ifdef BITSYNC_TIMEOUT_EN
    .wrap_o    (wrap),
`endif
    .clk32     (clk32),
    .rst       (rst),
    .edge_p_i  (edge_p),
    .coarse_i  (coarse),
    .data_in   (data_in),
    .cnt_o     (cnt),
    .err_o     (err),
    .bit_stb_o (bit_stb),
    .bit_out_o (bit_out)
  );

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    coarse  = 1'b0;
    perr_d  = edge_p ? err : perr_q;
    case (state_q)
      SEARCH: begin
        if (edge_p) begin
          coarse  = 1'b1;
          good_d  = '0;
          miss_d  = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (edge_p) begin
          if (in_win) begin
            good_d = good_q + 1'b1;
            if (good_d == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            good_d = '0;
            coarse = 1'b1;
          end
        end
      end
      LOCKED: begin
        // Only fine +/-1 steering here; a stray edge must not yank the phase.
        if (edge_p) begin
          if (in_win) begin
            miss_d = '0;
          end else begin
            miss_d = miss_q + 1'b1;
            if (miss_d == MISS_C) begin
              state_d = SEARCH;
              miss_d  = '0;
              good_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
    if (timeout && (state_q != SEARCH)) begin
      state_d = SEARCH;
      good_d  = '0;
      miss_d  = '0;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      edge_q  <= 1'b0;
      good_q  <= '0;
      miss_q  <= '0;
      perr_q  <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_in;
      good_q  <= good_d;
      miss_q  <= miss_d;
      perr_q  <= perr_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign sync_state = state_q;
  assign phase_err  = perr_q;

endmodule
